router_fsm: RTL
===============

ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001: Parameters: none; state encoding is internal and not visible at ports.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: resetn  input  1  asynchronous, active-low reset.
REQ-004: packet_valid  input  1  source is driving header/payload bytes.
REQ-005: datain  input  2  address field of the header byte (bits 1:0).
REQ-006: fifo_full  input  1  currently addressed output FIFO is full.
REQ-007: fifo_empty_0 / fifo_empty_1 / fifo_empty_2  input  1 each  output FIFO n empty.
REQ-008: soft_reset_0 / soft_reset_1 / soft_reset_2  input  1 each  output FIFO n timed out.
REQ-009: parity_done  input  1  register block has captured the parity byte.
REQ-010: low_packet_valid  input  1  register block saw packet_valid fall while full.
REQ-011: detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  output  1 each  state strobes to the register block.
REQ-012: write_enb_reg  output  1  write enable to the FIFO bank.
REQ-013: busy  output  1  back-pressure to the source; source holds data while high.

Function
REQ-014: The FSM SHALL have exactly eight states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
REQ-015: In DECODE_ADDRESS, with packet_valid=1, the FSM SHALL latch datain into a 2-bit address register; it SHALL NOT latch it in any other state.
REQ-016: DECODE_ADDRESS: packet_valid=1, datain!=2'b11, fifo_empty_<datain>=1 -> LOAD_FIRST_DATA; packet_valid=1, datain!=2'b11, fifo_empty_<datain>=0 -> WAIT_TILL_EMPTY; otherwise stay (address 2'b11 is dropped).
REQ-017: LOAD_FIRST_DATA -> LOAD_DATA unconditionally after one cycle.
REQ-018: LOAD_DATA: fifo_full=1 -> FIFO_FULL_STATE (priority); else packet_valid=0 -> LOAD_PARITY; else stay.
REQ-019: FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
REQ-020: LOAD_AFTER_FULL: parity_done=1 -> DECODE_ADDRESS; else low_packet_valid=1 -> LOAD_PARITY; else -> LOAD_DATA.
REQ-021: LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-022: CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
REQ-023: WAIT_TILL_EMPTY: fifo_empty_<latched address>=1 -> LOAD_FIRST_DATA; else stay.
REQ-024: soft_reset_<latched address>=1 SHALL force next state DECODE_ADDRESS from any state, overriding all other transitions; soft resets of other ports SHALL be ignored.
REQ-025: Outputs SHALL be Moore, decoded from current state only: detect_add=DECODE_ADDRESS, lfd_state=LOAD_FIRST_DATA, ld_state=LOAD_DATA, full_state=FIFO_FULL_STATE, laf_state=LOAD_AFTER_FULL, rst_int_reg=CHECK_PARITY_ERROR.
REQ-026: write_enb_reg SHALL be 1 in LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY; 0 elsewhere.
REQ-027: busy SHALL be 0 in DECODE_ADDRESS and LOAD_DATA; 1 in all other states.
REQ-028: Exactly one of the six state strobes SHALL be 1 in DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, CHECK_PARITY_ERROR; all six SHALL be 0 in LOAD_PARITY and WAIT_TILL_EMPTY.
REQ-029: Unreachable state encodings SHALL transition to DECODE_ADDRESS on the next edge.

Reset
REQ-030: resetn=0 SHALL immediately (asynchronously) force DECODE_ADDRESS and clear the address register to 2'b00.
REQ-031: During reset outputs SHALL be detect_add=1, all other strobes 0, write_enb_reg=0, busy=0.
REQ-032: Reset asserted mid-packet SHALL abandon the packet; no write_enb_reg pulse after resetn falls.

Verification
REQ-033: Reset, then header addr 2'b01 with fifo_empty_1=1, 8 payload bytes, fifo_full=0 -> states DA, LFD, LD x8, LP, CPE, DA; write_enb_reg high 9 cycles; busy high only in LFD, LP, CPE.
REQ-034: Header addr 2'b10 with fifo_empty_2=0 for 5 cycles -> WAIT_TILL_EMPTY for 5 cycles, busy=1, then LFD one cycle after fifo_empty_2 rises.
REQ-035: fifo_full=1 on 3rd LD cycle for 4 cycles -> FFS 4 cycles, write_enb_reg=0; then LAF, back to LD with low_packet_valid=0, parity_done=0.
REQ-036: In LD, assert soft_reset_0 with latched addr 0 -> DA next cycle; repeat with soft_reset_1 while addr 0 -> no effect.
REQ-037: Header datain=2'b11 with packet_valid=1 for 3 cycles -> stays DA, busy=0, write_enb_reg=0.
REQ-038: Drop resetn asynchronously mid-LD (between edges) -> detect_add=1, ld_state=0, write_enb_reg=0 before next rising edge.

Source files
------------

// File: rtl/router_fsm.sv
// Packet router control FSM: decodes the header address, sequences
// payload/parity loading and throttles the source around full FIFOs.
module router_fsm (
  input  logic       clk,
  input  logic       resetn,
  input  logic       packet_valid,
  input  logic [1:0] datain,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_packet_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t     state;
  state_t     next;
  logic [1:0] addr;
  logic       empty_in;
  logic       empty_addr;
  logic       srst;

  // Header address 2'b11 selects no port: never empty, never soft reset.
  always_comb begin
    empty_in = 1'b0;
    case (datain)
      2'd0:    empty_in = fifo_empty_0;
      2'd1:    empty_in = fifo_empty_1;
      2'd2:    empty_in = fifo_empty_2;
      default: empty_in = 1'b0;
    endcase
  end

  always_comb begin
    empty_addr = 1'b0;
    srst       = 1'b0;
    case (addr)
      2'd0: begin
        empty_addr = fifo_empty_0;
        srst       = soft_reset_0;
      end
      2'd1: begin
        empty_addr = fifo_empty_1;
        srst       = soft_reset_1;
      end
      2'd2: begin
        empty_addr = fifo_empty_2;
        srst       = soft_reset_2;
      end
      default: begin
        empty_addr = 1'b0;
        srst       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr <= 2'b00;
    end else if (state == DECODE_ADDRESS && packet_valid) begin
      addr <= datain;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= DECODE_ADDRESS;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    case (state)
      DECODE_ADDRESS: begin
        if (packet_valid && datain != 2'b11) begin
          next = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: next = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full) begin
          next = FIFO_FULL_STATE;
        end else if (!packet_valid) begin
          next = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) begin
          next = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        if (parity_done) begin
          next = DECODE_ADDRESS;
        end else if (low_packet_valid) begin
          next = LOAD_PARITY;
        end else begin
          next = LOAD_DATA;
        end
      end
      LOAD_PARITY: next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (empty_addr) begin
          next = LOAD_FIRST_DATA;
        end
      end
      default: next = DECODE_ADDRESS;
    endcase
    if (srst) begin
      next = DECODE_ADDRESS;
    end
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b1;
    case (state)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      LOAD_FIRST_DATA: lfd_state = 1'b1;
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      FIFO_FULL_STATE: full_state = 1'b1;
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_PARITY:        write_enb_reg = 1'b1;
      CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
      WAIT_TILL_EMPTY:    busy = 1'b1;
      default: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
    endcase
  end

endmodule
